rca_add64_seq: RTL and testbench



---
 rtl/rca_add64_seq_if.sv | 32 +++
 rtl/rca_add64_seq.sv | 134 +++++++++++++
 tb/tb_rca_add64_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rca_add64_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : rca_add64_seq_if
// Description : Operand/result handshake bundle for the sequential 64-bit
//               add/subtract unit. The master side supplies operands and
//               consumes results. The slave side is the arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface rca_add64_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/rca_add64_seq.sv
`default_nettype none
// ============================================================================
// Module      : rca_add64_seq (with leaf rca_32bit)
// Description : 64-bit add/subtract built from one 32-bit ripple-carry adder
//               that is used twice: low word first, then high word with the
//               registered mid carry. The result is held until it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================

// 32-bit ripple-carry adder slice.
module rca_32bit (
  input  wire logic [31:0] a,
  input  wire logic [31:0] b,
  input  wire logic        cin,
  output logic      [31:0] sum,
  output logic             cout
);
  logic [32:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[32];
endmodule

module rca_add64_seq (
  input  wire logic         clk,
  input  wire logic         rst_n,
  rca_add64_seq_if.slave    bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_a;
  logic [63:0] r_b_eff;      // B already inverted for subtract
  logic        r_cin_eff;    // carry-in already inverted for subtract
  logic [31:0] r_sum_lo;
  logic        r_carry_mid;
  logic [63:0] r_sum;
  logic        r_cout;
  logic        r_ovf;
  logic        r_out_valid;

  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic        w_add_cin;
  logic [31:0] w_add_sum;
  logic        w_add_cout;

  // Adder operand select: low word in LO, high word otherwise. Only the LO
  // and HI results are ever captured, so IDLE/DONE values do not matter.
  always_comb begin
    w_add_a   = r_a[63:32];
    w_add_b   = r_b_eff[63:32];
    w_add_cin = r_carry_mid;
    if (r_state == S_LO) begin
      w_add_a   = r_a[31:0];
      w_add_b   = r_b_eff[31:0];
      w_add_cin = r_cin_eff;
    end
  end

  rca_32bit u_adder (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  // Sequencer: accept, low pass, high pass, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b_eff     <= '0;
      r_cin_eff   <= 1'b0;
      r_sum_lo    <= '0;
      r_carry_mid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a       <= bus.in_a;
            r_b_eff   <= bus.in_sub ? ~bus.in_b : bus.in_b;
            r_cin_eff <= bus.in_sub ? ~bus.in_cin : bus.in_cin;
            r_state   <= S_LO;
          end
        end
        S_LO: begin
          r_sum_lo    <= w_add_sum;
          r_carry_mid <= w_add_cout;
          r_state     <= S_HI;
        end
        S_HI: begin
          r_sum       <= {w_add_sum, r_sum_lo};
          r_cout      <= w_add_cout;
          r_ovf       <= (r_a[63] == r_b_eff[63]) && (w_add_sum[31] != r_a[63]);
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && rst_n;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.out_ovf   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_rca_add64_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_add64_seq
// Description : Self-checking bench for rca_add64_seq: directed corner cases,
//               randomized operations with backpressure, and mid-op reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_add64_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rca_add64_seq_if bus ();

  rca_add64_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [65:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub);
    logic [64:0]        u;
    logic signed [65:0] s;
    logic               cout;
    logic               ovf;
    logic [63:0]        sum;
    s = $signed({{2{a[63]}}, a});
    if (!sub) begin
      u    = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      sum  = u[63:0];
      cout = u[64];
      s    = s + $signed({{2{b[63]}}, b}) + $signed({65'd0, cin});
    end else begin
      sum  = a - b - {63'd0, cin};
      cout = ({1'b0, a} >= ({1'b0, b} + {64'd0, cin}));
      s    = s - $signed({{2{b[63]}}, b}) - $signed({65'd0, cin});
    end
    ovf = (s > $signed({2'b00, 64'h7FFF_FFFF_FFFF_FFFF})) ||
          (s < $signed({2'b11, 64'h8000_0000_0000_0000}));
    return {ovf, cout, sum};
  endfunction

  task automatic randomize_inputs();
    bus.in_a   = {$urandom, $urandom};
    bus.in_b   = {$urandom, $urandom};
    bus.in_cin = 1'($urandom);
    bus.in_sub = 1'($urandom);
  endtask

  // Waits (bounded) for in_ready, presents operands, returns 1 on accept.
  task automatic present(input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    @(posedge clk);  // accept edge E0
    #1;
    bus.in_valid = 1'b0;
    randomize_inputs();
    ok = 1'b1;
  endtask

  // One full operation with 'hold' cycles of backpressure in DONE.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [65:0] e;
    bit          ok;
    e = ref_model(a, b, cin, sub);
    present(a, b, cin, sub, ok);
    if (!ok) return;
    check("lat_e0_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_e1_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_e2_valid", 64'(bus.out_valid), 64'd1);
    check("sum",  bus.out_sum, e[63:0]);
    check("cout", 64'(bus.out_cout), 64'(e[64]));
    check("ovf",  64'(bus.out_ovf),  64'(e[65]));
    check("ready_in_done", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      randomize_inputs();
      @(posedge clk); #1;
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_sum",   bus.out_sum, e[63:0]);
      check("bp_flags", {62'd0, bus.out_ovf, bus.out_cout}, {62'd0, e[65:64]});
      check("bp_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_hs_valid", 64'(bus.out_valid), 64'd0);
    check("post_hs_ready", 64'(bus.in_ready),  64'd1);
    check("post_hs_hold",  bus.out_sum, e[63:0]);
  endtask

  initial begin
    bit ok;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;

    #12;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum",   bus.out_sum, 64'd0);
    check("rst_flags", {62'd0, bus.out_ovf, bus.out_cout}, 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 64'(bus.in_ready), 64'd1);

    // Directed corner cases
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1);
    run_op(64'd0, 64'd0, 1'b1, 1'b0, 0);
    run_op(64'd5, 64'd7, 1'b0, 1'b1, 0);
    run_op(64'd7, 64'd5, 1'b1, 1'b1, 5);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 2);
    run_op(64'd0, 64'd0, 1'b0, 1'b1, 0);

    // Randomized operations with random backpressure
    for (int k = 0; k < 40; k++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    // Reset while the unit is in HI
    present(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, ok);
    if (ok) begin
      @(posedge clk); #1;   // now in HI
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_sum",   bus.out_sum, 64'd0);
      check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        check("no_stale_valid", 64'(bus.out_valid), 64'd0);
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);
      end
      run_op(64'd3, 64'd4, 1'b0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
